// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared opcodes, FSM encoding and immediate decoders
package branch_redirect_ctrl_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int BHT_DEPTH_DEFAULT = 16;

    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_bht_2bit.sv
// rtl/branch_redirect_ctrl_bht_2bit.sv - 2-bit saturating counter table, async read, sync update
module bht_2bit
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = BHT_DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] upd_old;
    logic [1:0] upd_new;

    assign rd_ctr_o = ctr_q[rd_idx_i];
    assign upd_old  = ctr_q[upd_idx_i];

    always_comb begin
        upd_new = upd_old;
        if (upd_taken_i) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= upd_new;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - ID-stage branch redirect and EX mispredict recovery
// BRANCH_REDIRECT_PREDICT_EN enables the counter table; otherwise B-types predict not-taken.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_instr_i,
    input  logic        ex_valid_i,
    input  logic        ex_taken_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        pending_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [31:0]      ft_q, ft_d;
    logic             pred_q, pred_d;

    logic [6:0]       opcode;
    logic             is_jal, is_br;
    logic [IDX_W-1:0] id_idx;
    logic [31:0]      br_tgt, jal_tgt, fall_thru;
    logic             resolve, mispredict, id_ok, accept_br;
    logic             pred_taken;

    assign opcode    = id_instr_i[6:0];
    assign is_jal    = (opcode == OPC_JAL);
    assign is_br     = (opcode == OPC_BRANCH);
    assign id_idx    = id_pc_i[IDX_W+1:2];
    assign br_tgt    = id_pc_i + imm_b(id_instr_i);
    assign jal_tgt   = id_pc_i + imm_j(id_instr_i);
    assign fall_thru = id_pc_i + 32'd4;

    assign resolve    = (state_q == ST_WAIT) && ex_valid_i;
    assign mispredict = resolve && (ex_taken_i != pred_q);
    assign id_ok      = id_valid_i && !stall_i && !mispredict;
    // Only one branch can be tracked: a new B-type is taken only when the slot frees.
    assign accept_br  = id_ok && is_br && ((state_q == ST_IDLE) || resolve);

`ifdef BRANCH_REDIRECT_PREDICT_EN
    logic [1:0] rd_ctr;

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (id_idx),
        .rd_ctr_o    (rd_ctr),
        .upd_en_i    (resolve),
        .upd_idx_i   (idx_q),
        .upd_taken_i (ex_taken_i)
    );

    assign pred_taken = rd_ctr[1];
`else
    assign pred_taken = 1'b0;
`endif

    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = 32'd0;
        flush_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        pending_o     = 1'b0;
        if (!rst_i) begin
            pending_o = (state_q == ST_WAIT);
            if (mispredict) begin
                redirect_o    = 1'b1;
                redirect_pc_o = ex_taken_i ? tgt_q : ft_q;
                flush_if_o    = 1'b1;
                flush_id_o    = 1'b1;
            end else if (id_ok && is_jal) begin
                redirect_o    = 1'b1;
                redirect_pc_o = jal_tgt;
                flush_if_o    = 1'b1;
            end else if (accept_br && pred_taken) begin
                redirect_o    = 1'b1;
                redirect_pc_o = br_tgt;
                flush_if_o    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        ft_d    = ft_q;
        pred_d  = pred_q;
        if (resolve) state_d = ST_IDLE;
        if (accept_br) begin
            state_d = ST_WAIT;
            idx_d   = id_idx;
            tgt_d   = br_tgt;
            ft_d    = fall_thru;
            pred_d  = pred_taken;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tgt_q   <= 32'd0;
            ft_q    <= 32'd0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            ft_q    <= ft_d;
            pred_q  <= pred_d;
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

    localparam logic [31:0] JAL_I = 32'h0200006F;
    localparam logic [31:0] BEQ_I = 32'hFE000CE3;
    localparam logic [31:0] JALR_I = 32'h00008067;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, id_valid_i, ex_valid_i, ex_taken_i;
    logic [31:0] id_pc_i, id_instr_i;
    logic        redirect_o, flush_if_o, flush_id_o, pending_o;
    logic [31:0] redirect_pc_o;

    int n_checks = 0;
    int n_pass   = 0;

    branch_redirect_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .id_valid_i    (id_valid_i),
        .id_pc_i       (id_pc_i),
        .id_instr_i    (id_instr_i),
        .ex_valid_i    (ex_valid_i),
        .ex_taken_i    (ex_taken_i),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_if_o    (flush_if_o),
        .flush_id_o    (flush_id_o),
        .pending_o     (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input logic red, input logic [31:0] pc,
                              input logic fif, input logic fid, input logic pend);
        #1;
        chk({tag, ".redirect"}, 32'(redirect_o), 32'(red));
        chk({tag, ".pc"},       redirect_pc_o,   pc);
        chk({tag, ".flush_if"}, 32'(flush_if_o), 32'(fif));
        chk({tag, ".flush_id"}, 32'(flush_id_o), 32'(fid));
        chk({tag, ".pending"},  32'(pending_o),  32'(pend));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        id_valid_i = v;
        id_pc_i    = pc;
        id_instr_i = ins;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; ex_valid_i = 1'b0; ex_taken_i = 1'b0;
        set_id(1'b0, 32'd0, 32'd0);

        cyc();
        set_id(1'b1, 32'h100, JAL_I);
        expect_out("in_reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst_i = 1'b0;
        expect_out("jal", 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        expect_out("jal_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // First BEQ: weakly not-taken, resolves taken
        set_id(1'b1, 32'h200, BEQ_I);
        expect_out("beq1_id", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        expect_out("beq1_wait", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        ex_valid_i = 1'b1; ex_taken_i = 1'b1;
        expect_out("beq1_ex", 1'b1, 32'h1F8, 1'b1, 1'b1, 1'b1);
        cyc();
        ex_valid_i = 1'b0;
        expect_out("beq1_done", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Second BEQ: counter at 10 predicts taken when the table is built
        set_id(1'b1, 32'h200, BEQ_I);
`ifdef BRANCH_REDIRECT_PREDICT_EN
        expect_out("beq2_id", 1'b1, 32'h1F8, 1'b1, 1'b0, 1'b0);
`else
        expect_out("beq2_id", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`endif
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        ex_valid_i = 1'b1;
`ifdef BRANCH_REDIRECT_PREDICT_EN
        ex_taken_i = 1'b0;
        expect_out("beq2_ex", 1'b1, 32'h204, 1'b1, 1'b1, 1'b1);
`else
        ex_taken_i = 1'b1;
        expect_out("beq2_ex", 1'b1, 32'h1F8, 1'b1, 1'b1, 1'b1);
`endif
        cyc();
        ex_valid_i = 1'b0;
        expect_out("beq2_done", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        set_id(1'b1, 32'h400, JALR_I);
        expect_out("jalr", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        expect_out("jalr_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Stalled BEQ must not be evaluated
        set_id(1'b1, 32'h200, BEQ_I);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("stall", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        stall_i = 1'b0;
        expect_out("unstall", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Correct resolution overlapping a new BEQ keeps WAIT
        set_id(1'b1, 32'h300, BEQ_I);
        ex_valid_i = 1'b1; ex_taken_i = 1'b0;
        expect_out("overlap", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        set_id(1'b1, 32'h500, JAL_I);
        ex_taken_i = 1'b1;
        expect_out("mp_over_jal", 1'b1, 32'h2F8, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        ex_valid_i = 1'b0;
        expect_out("mp_done", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Train index 0 to 10, then reset while waiting
        set_id(1'b1, 32'h200, BEQ_I);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        ex_valid_i = 1'b1; ex_taken_i = 1'b1;
        expect_out("train", 1'b1, 32'h1F8, 1'b1, 1'b1, 1'b1);
        cyc();
        ex_valid_i = 1'b0;
        set_id(1'b1, 32'h200, BEQ_I);
`ifdef BRANCH_REDIRECT_PREDICT_EN
        expect_out("trained", 1'b1, 32'h1F8, 1'b1, 1'b0, 1'b0);
`else
        expect_out("trained", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`endif
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        expect_out("pre_rst_wait", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        rst_i = 1'b1; ex_valid_i = 1'b1; ex_taken_i = 1'b0;
        expect_out("rst_in_wait", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst_i = 1'b0;
        expect_out("post_rst_ex", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        ex_valid_i = 1'b0;
        set_id(1'b1, 32'h200, BEQ_I);
        expect_out("ctr_reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        set_id(1'b0, 32'd0, 32'd0);
        ex_valid_i = 1'b1; ex_taken_i = 1'b0;
        expect_out("final_ok", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        ex_valid_i = 1'b0;
        expect_out("final_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter BHT_DEPTH, default 16, meaning number of branch history entries (power of two, 2..64).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  pipeline stall; ID stage frozen.
REQ-005 id_valid_i  input  1  ID holds a valid instruction.
REQ-006 id_pc_i  input  32  PC of the ID instruction.
REQ-007 id_instr_i  input  32  raw ID instruction word.
REQ-008 ex_valid_i  input  1  EX holds the pending conditional branch, outcome valid.
REQ-009 ex_taken_i  input  1  actual outcome of that branch.
REQ-010 redirect_o  output  1  fetch redirect this cycle.
REQ-011 redirect_pc_o  output  32  new fetch PC, valid when redirect_o=1, else 0.
REQ-012 flush_if_o  output  1  squash the IF instruction.
REQ-013 flush_id_o  output  1  squash the ID instruction.
REQ-014 pending_o  output  1  a predicted branch awaits resolution.

Function
REQ-015 Immediates SHALL be: B-type (opcode 1100011) sign-ext {instr[31],instr[7],instr[30:25],instr[11:8],0}; JAL (opcode 1101111) sign-ext {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-016 Target SHALL be id_pc_i + imm, modulo 2^32; fall-through SHALL be id_pc_i + 4, modulo 2^32.
REQ-017 FSM SHALL have states IDLE and WAIT; pending_o=1 exactly in WAIT.
REQ-018 ID evaluation SHALL occur only when id_valid_i=1, stall_i=0, and no mispredict in the same cycle; other opcodes (incl. JALR) produce no action.
REQ-019 JAL in ID: redirect_o=1, redirect_pc_o=target, flush_if_o=1, same cycle (combinational); state unchanged.
REQ-020 B-type in ID: read 2-bit counter at index id_pc_i[log2(BHT_DEPTH)+1:2]; predict taken if counter MSB=1, then redirect to target with flush_if_o=1; otherwise no output.
REQ-021 B-type in ID SHALL latch {index, target, fall-through, prediction} and go to WAIT at the next edge.
REQ-022 In WAIT with ex_valid_i=1: outcome != prediction is a mispredict: redirect_o=1, redirect_pc_o = target if taken else fall-through, flush_if_o=1, flush_id_o=1, same cycle.
REQ-023 On resolution the counter SHALL saturate-increment (taken) or saturate-decrement (not taken) at the edge; FSM returns to IDLE unless REQ-024 applies.
REQ-024 Correct resolution and new B-type in ID in the same cycle: both handled; the new branch is latched and FSM stays in WAIT.
REQ-025 Mispredict SHALL override any ID action that cycle; the ID instruction is ignored.
REQ-026 ex_valid_i in IDLE SHALL be ignored.
REQ-027 stall_i SHALL NOT block EX resolution.
REQ-028 Index collision during resolution SHALL use the updated counter from the next cycle onward.

Reset
REQ-029 rst_i=1 at an edge: FSM to IDLE, latched branch data cleared, all counters to 2'b01 (weakly not-taken); this applies from any state, including WAIT.
REQ-030 While rst_i=1, all outputs SHALL be 0.

Configuration
REQ-031 Macro BRANCH_REDIRECT_PREDICT_EN defined: counter table present per REQ-020/023.
REQ-032 Undefined: no table, every B-type predicted not-taken, mispredict recovery and JAL redirect unchanged; BHT_DEPTH unused.

Structure
REQ-033 Shared package SHALL hold opcode constants (OPC_BRANCH, OPC_JAL), FSM state encoding, and default BHT_DEPTH.
REQ-034 The counter table SHALL be sub-module bht_2bit: one combinational read port, one synchronous update port, and a synchronous reset.

Verification
REQ-035 JAL 0x0200006F at PC 0x100 -> same cycle: redirect_o=1, redirect_pc_o=0x120, flush_if_o=1, pending_o stays 0.
REQ-036 After reset, BEQ 0xFE000CE3 (imm -8) at PC 0x200 -> no redirect, pending_o=1; then EX taken -> redirect_pc_o=0x1F8, flush_if_o=flush_id_o=1; counter becomes 10.
REQ-037 Same BEQ again -> ID redirect to 0x1F8 with flush_if_o=1; EX not taken -> redirect_pc_o=0x204, both flushes; counter returns to 01.
REQ-038 BEQ in ID with stall_i=1 for 3 cycles -> no outputs and state IDLE until stall_i falls.
REQ-039 rst_i during WAIT -> next cycle pending_o=0, outputs 0; later ex_valid_i ignored; all counters read 01.
REQ-040 Build without BRANCH_REDIRECT_PREDICT_EN and repeat REQ-037 -> no ID redirect; EX taken -> redirect to 0x1F8.
